// File: rtl/io_switch_in_pkg.sv
// Shared constants for the switch input block: register addresses, bus width, channel roles.
package switch_in_pkg;

  localparam logic [1:0] SW_ADDR_LEVEL   = 2'd0;
  localparam logic [1:0] SW_ADDR_PRESS   = 2'd1;
  localparam logic [1:0] SW_ADDR_RELEASE = 2'd2;
  localparam logic [1:0] SW_ADDR_MASK    = 2'd3;

  localparam int SW_REG_WIDTH = 32;

  localparam int SW_CH = 0;
  localparam int SW_CE = 1;
  localparam int SW_CP = 2;

endpackage

// File: rtl/io_switch_in_debounce.sv
// One switch channel: 2-FF synchroniser, stability counter and accepted level.
// o_rise/o_fall flag the clock edge on which the level is about to change.
module switch_debounce #(
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter bit RESET_LEVEL     = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_raw,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_ff1;
  logic          r_ff2;
  logic          r_level;
  logic [CW-1:0] r_cnt;
  logic          w_accept;

  // The counter holds the number of consecutive mismatching cycles already seen.
  assign w_accept = (r_ff2 != r_level) && (r_cnt == CNT_LAST);
  assign o_rise   = w_accept & r_ff2;
  assign o_fall   = w_accept & ~r_ff2;
  assign o_level  = r_level;

  // Synchroniser, debounce counter and accepted level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ff1   <= RESET_LEVEL;
      r_ff2   <= RESET_LEVEL;
      r_level <= RESET_LEVEL;
      r_cnt   <= CNT_ZERO;
    end else begin
      r_ff1 <= i_raw;
      r_ff2 <= r_ff1;
      if (r_ff2 == r_level) begin
        r_cnt <= CNT_ZERO;
      end else if (w_accept) begin
        r_level <= r_ff2;
        r_cnt   <= CNT_ZERO;
      end else begin
        r_cnt <= r_cnt + CNT_ONE;
      end
    end
  end

endmodule

// File: rtl/io_switch_in.sv
// Debounced switch inputs with sticky W1C press/release flags for the CPU.
// Define SWITCH_IN_IRQ_EN to add the MASK register and the irq output.
module io_switch_in
  import switch_in_pkg::*;
#(
  parameter int NUM_SW          = 3,
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter bit RESET_LEVEL     = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_SW-1:0]       swRaw,
  output logic [NUM_SW-1:0]       swLevel,
  input  logic [1:0]              rdAddr,
  output logic [SW_REG_WIDTH-1:0] rdData,
  input  logic                    wrEnable,
  input  logic [1:0]              wrAddr,
`ifdef SWITCH_IN_IRQ_EN
  output logic                    irq,
`endif
  input  logic [SW_REG_WIDTH-1:0] wrData
);

  logic [NUM_SW-1:0] w_rise;
  logic [NUM_SW-1:0] w_fall;
  logic [NUM_SW-1:0] w_press_clr;
  logic [NUM_SW-1:0] w_release_clr;
  logic [NUM_SW-1:0] r_press;
  logic [NUM_SW-1:0] r_release;
  logic              w_unused_wr;

  assign w_unused_wr = ^wrData;

  for (genvar i = 0; i < NUM_SW; i++) begin : g_ch
    switch_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .RESET_LEVEL    (RESET_LEVEL)
    ) u_db (
      .clk    (clk),
      .rst    (rst),
      .i_raw  (swRaw[i]),
      .o_level(swLevel[i]),
      .o_rise (w_rise[i]),
      .o_fall (w_fall[i])
    );
  end

  // Decode write-one-to-clear strobes for the event registers.
  always_comb begin
    w_press_clr   = {NUM_SW{1'b0}};
    w_release_clr = {NUM_SW{1'b0}};
    if (wrEnable && (wrAddr == SW_ADDR_PRESS)) begin
      w_press_clr = wrData[NUM_SW-1:0];
    end else if (wrEnable && (wrAddr == SW_ADDR_RELEASE)) begin
      w_release_clr = wrData[NUM_SW-1:0];
    end else begin
      w_press_clr   = {NUM_SW{1'b0}};
      w_release_clr = {NUM_SW{1'b0}};
    end
  end

  // Sticky event flags; a new event in the same cycle beats the clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_press   <= {NUM_SW{1'b0}};
      r_release <= {NUM_SW{1'b0}};
    end else begin
      r_press   <= (r_press & ~w_press_clr) | w_fall;
      r_release <= (r_release & ~w_release_clr) | w_rise;
    end
  end

`ifdef SWITCH_IN_IRQ_EN
  logic [NUM_SW-1:0] r_mask;
  logic              r_irq;

  // Interrupt mask and registered interrupt request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mask <= {NUM_SW{1'b0}};
      r_irq  <= 1'b0;
    end else begin
      if (wrEnable && (wrAddr == SW_ADDR_MASK)) begin
        r_mask <= wrData[NUM_SW-1:0];
      end
      r_irq <= |(r_press & r_mask);
    end
  end

  assign irq = r_irq;
`endif

  // Read mux, zero-extended to the bus width.
  always_comb begin
    rdData = {SW_REG_WIDTH{1'b0}};
    case (rdAddr)
      SW_ADDR_LEVEL:   rdData[NUM_SW-1:0] = swLevel;
      SW_ADDR_PRESS:   rdData[NUM_SW-1:0] = r_press;
      SW_ADDR_RELEASE: rdData[NUM_SW-1:0] = r_release;
`ifdef SWITCH_IN_IRQ_EN
      SW_ADDR_MASK:    rdData[NUM_SW-1:0] = r_mask;
`else
      SW_ADDR_MASK:    rdData = {SW_REG_WIDTH{1'b0}};
`endif
      default:         rdData = {SW_REG_WIDTH{1'b0}};
    endcase
  end

endmodule

// File: tb/tb_io_switch_in.sv
// Directed bench for io_switch_in with NUM_SW=3, DEBOUNCE_CYCLES=4.
module tb_io_switch_in;

  logic        clk;
  logic        rst;
  logic [2:0]  swRaw;
  logic [2:0]  swLevel;
  logic [1:0]  rdAddr;
  logic [31:0] rdData;
  logic        wrEnable;
  logic [1:0]  wrAddr;
  logic [31:0] wrData;
`ifdef SWITCH_IN_IRQ_EN
  logic        irq;
`endif

  int checks   = 0;
  int failures = 0;

  io_switch_in #(.NUM_SW(3), .DEBOUNCE_CYCLES(4), .RESET_LEVEL(1'b1)) dut (
    .clk     (clk),
    .rst     (rst),
    .swRaw   (swRaw),
    .swLevel (swLevel),
    .rdAddr  (rdAddr),
    .rdData  (rdData),
    .wrEnable(wrEnable),
    .wrAddr  (wrAddr),
`ifdef SWITCH_IN_IRQ_EN
    .irq     (irq),
`endif
    .wrData  (wrData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic rd(input string tag, input logic [1:0] a, input logic [31:0] exp);
    rdAddr = a;
    #1;
    chk(tag, rdData, exp);
  endtask

  // One-cycle CPU write, returning at the following negedge.
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    wrEnable = 1'b1;
    wrAddr   = a;
    wrData   = d;
    step(1);
    wrEnable = 1'b0;
    wrData   = 32'h0;
  endtask

  initial begin
    rst      = 1'b0;
    swRaw    = 3'b111;
    rdAddr   = 2'd0;
    wrEnable = 1'b0;
    wrAddr   = 2'd0;
    wrData   = 32'h0;
    step(3);
    chk("level_in_reset", {29'd0, swLevel}, 32'h7);
    rst = 1'b1;
    step(1);
    rd("rst_level", 2'd0, 32'h7);
    rd("rst_press", 2'd1, 32'h0);
    rd("rst_release", 2'd2, 32'h0);
    rd("rst_mask", 2'd3, 32'h0);

    // ch0 press: level changes on the 6th rising edge after the raw step
    swRaw = 3'b110;
    step(5);
    chk("ch0_not_yet", {29'd0, swLevel}, 32'h7);
    step(1);
    chk("ch0_pressed", {29'd0, swLevel}, 32'h6);
    rd("ch0_press_flag", 2'd1, 32'h1);
    rd("ch0_no_release", 2'd2, 32'h0);

    // ch1 glitch of 3 cycles is rejected
    swRaw = 3'b100;
    step(3);
    swRaw = 3'b110;
    step(10);
    chk("glitch_level", {29'd0, swLevel}, 32'h6);
    rd("glitch_press", 2'd1, 32'h1);

    // ch1 low for exactly 4 cycles is accepted, then releases again
    swRaw = 3'b100;
    step(4);
    swRaw = 3'b110;
    step(2);
    chk("pulse4_level", {29'd0, swLevel}, 32'h4);
    rd("pulse4_press", 2'd1, 32'h3);
    wr(2'd1, 32'h1);
    rd("w1c_bit0", 2'd1, 32'h2);
    step(3);
    chk("ch1_released", {29'd0, swLevel}, 32'h6);
    rd("ch1_release_flag", 2'd2, 32'h2);
    wr(2'd2, 32'hFFFF_FFFF);
    rd("release_cleared", 2'd2, 32'h0);
    wr(2'd0, 32'h0);
    rd("level_write_ignored", 2'd0, 32'h6);
    wr(2'd1, 32'h2);
    rd("press_cleared", 2'd1, 32'h0);

    // W1C of bit1 on the very edge bit1 sets: set wins
    swRaw = 3'b100;
    step(5);
    wr(2'd1, 32'h2);
    chk("collide_level", {29'd0, swLevel}, 32'h4);
    rd("collide_set_wins", 2'd1, 32'h2);
    wr(2'd1, 32'h2);
    rd("collide_then_clear", 2'd1, 32'h0);

    // ch0 release
    swRaw = 3'b101;
    step(6);
    chk("ch0_release_level", {29'd0, swLevel}, 32'h5);
    rd("ch0_release_flag", 2'd2, 32'h1);

    // reset in the middle of a ch2 debounce
    swRaw = 3'b001;
    step(3);
    rst = 1'b0;
    step(1);
    chk("midrst_level", {29'd0, swLevel}, 32'h7);
    rd("midrst_press", 2'd1, 32'h0);
    rd("midrst_release", 2'd2, 32'h0);
    swRaw = 3'b111;
    rst = 1'b1;
    step(10);
    chk("postrst_level", {29'd0, swLevel}, 32'h7);
    rd("postrst_press", 2'd1, 32'h0);
    rd("postrst_release", 2'd2, 32'h0);

`ifdef SWITCH_IN_IRQ_EN
    wr(2'd3, 32'h4);
    rd("mask_rd", 2'd3, 32'h4);
    swRaw = 3'b011;
    step(6);
    rd("irq_press_flag", 2'd1, 32'h4);
    chk("irq_lags_flag", {31'd0, irq}, 32'h0);
    step(1);
    chk("irq_high", {31'd0, irq}, 32'h1);
    wr(2'd1, 32'h4);
    rd("irq_w1c_flag", 2'd1, 32'h0);
    chk("irq_still_high", {31'd0, irq}, 32'h1);
    step(1);
    chk("irq_low", {31'd0, irq}, 32'h0);
    swRaw = 3'b010;
    step(7);
    rd("irq_ch0_flag", 2'd1, 32'h1);
    chk("irq_masked_ch0", {31'd0, irq}, 32'h0);
`else
    wr(2'd3, 32'h4);
    rd("mask_absent", 2'd3, 32'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
